// File: rtl/afu_io_ctrl_if.sv
// Bundle of handshake and bus signals between afu_io_ctrl and its environment:
// context/start, CCI-style read and write channels, and afu_user FIFO ports.
interface afu_io_ctrl_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int BUFF_DEPTH_BITS = 3
);
  logic                       ctx_start;
  logic [ADDR_WIDTH-1:0]      ctx_src_addr;
  logic [ADDR_WIDTH-1:0]      ctx_dst_addr;
  logic [31:0]                ctx_length;
  logic                       done;
  logic                       rd_req_valid;
  logic [ADDR_WIDTH-1:0]      rd_req_addr;
  logic                       rd_req_almostfull;
  logic                       rd_rsp_valid;
  logic [511:0]               rd_rsp_data;
  logic [511:0]               input_fifo_din;
  logic                       input_fifo_we;
  logic                       input_fifo_full;
  logic [BUFF_DEPTH_BITS-1:0] input_fifo_count;
  logic [511:0]               output_fifo_dout;
  logic                       output_fifo_re;
  logic                       output_fifo_empty;
  logic                       wr_req_valid;
  logic [ADDR_WIDTH-1:0]      wr_req_addr;
  logic [511:0]               wr_req_data;
  logic                       wr_req_almostfull;
  logic                       wr_rsp_valid;

  // I/O engine side
  modport master (
    input  ctx_start, ctx_src_addr, ctx_dst_addr, ctx_length,
    output done,
    output rd_req_valid, rd_req_addr,
    input  rd_req_almostfull, rd_rsp_valid, rd_rsp_data,
    output input_fifo_din, input_fifo_we,
    input  input_fifo_full, input_fifo_count,
    input  output_fifo_dout, output_fifo_empty,
    output output_fifo_re,
    output wr_req_valid, wr_req_addr, wr_req_data,
    input  wr_req_almostfull, wr_rsp_valid
  );

  // Host, memory and afu_user side
  modport slave (
    output ctx_start, ctx_src_addr, ctx_dst_addr, ctx_length,
    input  done,
    input  rd_req_valid, rd_req_addr,
    output rd_req_almostfull, rd_rsp_valid, rd_rsp_data,
    input  input_fifo_din, input_fifo_we,
    output input_fifo_full, input_fifo_count,
    output output_fifo_dout, output_fifo_empty,
    input  output_fifo_re,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    output wr_req_almostfull, wr_rsp_valid
  );
endinterface

// File: rtl/afu_io_ctrl.sv
// Host-side I/O engine: streams source lines into afu_user under credit
// control, drains afu_user results into destination writes, and raises a
// sticky done once every write has been acknowledged.
module afu_io_ctrl #(
  parameter int ADDR_WIDTH      = 32,
  parameter int BUFF_DEPTH_BITS = 3
) (
  input  logic          clk,
  input  logic          reset,
  afu_io_ctrl_if.master io
);
  localparam int CW = BUFF_DEPTH_BITS + 2;
  localparam logic [CW-1:0] CAP = CW'(1 << BUFF_DEPTH_BITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    src_q, dst_q;
  logic [31:0]              len_q;
  logic [31:0]              rd_issued_q, wr_issued_q, wr_ack_q;
  logic [BUFF_DEPTH_BITS:0] rd_inflight_q;
  logic                     re_pending_q;

  logic                     load;
  logic                     rd_go;
  logic                     re_go;
  logic [CW-1:0]            occupancy;
  logic [CW-1:0]            credit_used;
  logic                     rsp_ok;

  // A full FIFO reports count==0, so full adds the whole depth back in.
  assign occupancy   = {2'b00, io.input_fifo_count} + (io.input_fifo_full ? CAP : '0);
  assign credit_used = {1'b0, rd_inflight_q} + occupancy;
  // Responses with nothing outstanding are protocol errors and do not count.
  assign rsp_ok      = io.rd_rsp_valid && (rd_inflight_q != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, context load and request strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    rd_go   = 1'b0;
    re_go   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (io.ctx_start) begin
          load    = 1'b1;
          state_d = (io.ctx_length == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_go = (rd_issued_q < len_q) && !io.rd_req_almostfull && (credit_used < CAP);
        re_go = !io.output_fifo_empty && !io.wr_req_almostfull &&
                (({1'b0, wr_issued_q} + {32'd0, re_pending_q}) < {1'b0, len_q});
        if (wr_ack_q == len_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Context registers and the independent progress counters
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      rd_issued_q   <= '0;
      wr_issued_q   <= '0;
      wr_ack_q      <= '0;
      rd_inflight_q <= '0;
      re_pending_q  <= 1'b0;
    end else if (load) begin
      src_q         <= io.ctx_src_addr;
      dst_q         <= io.ctx_dst_addr;
      len_q         <= io.ctx_length;
      rd_issued_q   <= '0;
      wr_issued_q   <= '0;
      wr_ack_q      <= '0;
      rd_inflight_q <= '0;
      re_pending_q  <= 1'b0;
    end else begin
      if (rd_go) rd_issued_q <= rd_issued_q + 32'd1;
      if (rd_go && !rsp_ok)      rd_inflight_q <= rd_inflight_q + 1'b1;
      else if (!rd_go && rsp_ok) rd_inflight_q <= rd_inflight_q - 1'b1;
      re_pending_q <= re_go;
      if (re_pending_q)    wr_issued_q <= wr_issued_q + 32'd1;
      if (io.wr_rsp_valid) wr_ack_q    <= wr_ack_q + 32'd1;
    end
  end

  assign io.done           = (state_q == DONE);
  assign io.rd_req_valid   = rd_go;
  assign io.rd_req_addr    = src_q + ADDR_WIDTH'(rd_issued_q);
  assign io.input_fifo_we  = io.rd_rsp_valid;
  assign io.input_fifo_din = io.rd_rsp_valid ? io.rd_rsp_data : '0;
  assign io.output_fifo_re = re_go;
  assign io.wr_req_valid   = re_pending_q;
  assign io.wr_req_addr    = dst_q + ADDR_WIDTH'(wr_issued_q);
  assign io.wr_req_data    = re_pending_q ? io.output_fifo_dout : '0;
endmodule

// File: doc/afu_io_ctrl.md
Name: afu_io_ctrl

Overview:
- Host-side I/O engine on the other end of the afu_user FIFO interface.
- Issues cache-line read requests over a source buffer and pushes the read responses into afu_user's input FIFO under credit control.
- Drains afu_user's output FIFO and issues cache-line write requests to a destination buffer.
- Asserts done once every write has been acknowledged. Sits between the memory/CCI request channels and afu_user.

Parameters:
- ADDR_WIDTH, 32, cache-line address width (one address unit = 64 B line).
- BUFF_DEPTH_BITS, 3, log2 depth of afu_user's input FIFO; must match afu_user.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ctx_start  in  1  one-cycle pulse; latches context and begins a run
- ctx_src_addr  in  ADDR_WIDTH  first source line address
- ctx_dst_addr  in  ADDR_WIDTH  first destination line address
- ctx_length  in  32  number of lines to read, and number to write
- done  out  1  run complete; sticky
- rd_req_valid  out  1  read request strobe
- rd_req_addr  out  ADDR_WIDTH  read line address
- rd_req_almostfull  in  1  read channel back-pressure
- rd_rsp_valid  in  1  read response strobe; responses arrive in request order
- rd_rsp_data  in  512  read response line
- input_fifo_din  out  512  to afu_user
- input_fifo_we  out  1  to afu_user
- input_fifo_full  in  1  from afu_user
- input_fifo_count  in  BUFF_DEPTH_BITS  from afu_user
- output_fifo_dout  in  512  from afu_user; valid one cycle after re
- output_fifo_re  out  1  to afu_user
- output_fifo_empty  in  1  from afu_user
- wr_req_valid  out  1  write request strobe
- wr_req_addr  out  ADDR_WIDTH  write line address
- wr_req_data  out  512  write line data
- wr_req_almostfull  in  1  write channel back-pressure
- wr_rsp_valid  in  1  write completion strobe, one per line

Behaviour:
- Reset values: all outputs 0; all counters 0; state IDLE. Reset mid-run aborts the run immediately and clears all state. Lost in-flight responses are the system's concern.
- States:
  - IDLE: on ctx_start, latch src, dst and length, clear counters. If length==0 go to DONE, else go to RUN.
  - RUN: read and write engines active. Go to DONE when wr_ack_cnt==length.
  - DONE: done=1. A new ctx_start relatches the context and re-enters RUN (or stays in DONE if length==0). ctx_start is ignored in RUN.
- Read engine:
  - rd_req_valid=1 in a cycle iff state==RUN, rd_issued<length, !rd_req_almostfull, and credit available.
  - rd_req_addr = src + rd_issued (mod 2^ADDR_WIDTH; wrap is allowed).
  - Credit: occupancy = input_fifo_count + (input_fifo_full ? 2^BUFF_DEPTH_BITS : 0). Issue only if rd_inflight + occupancy < 2^BUFF_DEPTH_BITS.
  - rd_inflight increments on issue and decrements on rd_rsp_valid. On the same cycle it is unchanged.
- Response path:
  - input_fifo_we = rd_rsp_valid, combinational pass-through; input_fifo_din = rd_rsp_data.
  - Responses are never dropped; the credit rule guarantees the FIFO is not full on arrival.
  - An rd_rsp_valid while rd_inflight==0 is a protocol error; ignore it and leave rd_inflight unchanged.
- Write engine:
  - output_fifo_re=1 iff state==RUN, !output_fifo_empty, !wr_req_almostfull, and wr_issued + re_pending < length.
  - re_pending is a 1-bit register, re_pending <= output_fifo_re.
  - wr_req_valid = re_pending, registered; wr_req_data = output_fifo_dout; wr_req_addr = dst + wr_issued.
  - wr_issued increments when wr_req_valid=1.
  - Write latency: re at cycle N gives wr_req_valid at cycle N+1.
  - wr_req_almostfull must leave at least 1 entry of slack.
- wr_ack_cnt increments on wr_rsp_valid. Completion is judged on acks, not issues.
- Counter widths are 32 bits; rd_inflight is BUFF_DEPTH_BITS+1 bits.
- Simultaneous events: rd_req issue, rd_rsp, output_fifo_re and wr_rsp may all occur in one cycle, and each counter updates independently.

Test Plan:
- Reset with all inputs idle, then ctx_start with length=0 -> done=1 on the next cycle; no rd_req_valid or wr_req_valid ever asserted.
- length=4, src=0x100, dst=0x200, memory model answers with 3-cycle latency, transposing afu_user in loop -> reads to 0x100..0x103, writes to 0x200..0x203 in order; done after the 4th wr_rsp.
- length=32, BUFF_DEPTH_BITS=3, afu_user output stalled (output_fifo_empty held 1) -> rd_inflight + occupancy never exceeds 8; input_fifo_we never asserted while input_fifo_full=1.
- Hold rd_req_almostfull=1 and wr_req_almostfull=1 for 20 cycles mid-run with length=16 -> no requests during the stall; run resumes; exactly 16 reads and 16 writes, with no duplicate or skipped addresses.
- src=0xFFFFFFFE, length=4 -> rd_req_addr sequence FFFFFFFE, FFFFFFFF, 0, 1.
- Assert reset after 5 of 10 lines written -> all outputs 0 the next cycle; a new ctx_start with length=3 then completes cleanly with done=1.
